// File: rtl/mimosa_pkg.sv
// Shared constants for the creature-state schedulers: indicator encoding and
// default energy datapath sizing.
package mimosa_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_STEP  = 4;

  typedef enum logic [1:0] {
    IND_LOW  = 2'd0,
    IND_MED  = 2'd1,
    IND_HIGH = 2'd2,
    IND_FULL = 2'd3
  } energy_ind_e;

endpackage

// File: rtl/energy_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first pending index at or above ptr,
// wrapping modulo N. Shared by the energy/stress/hunger schedulers.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + 32'(k)) % 32'(N));
      if (!valid && pending[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/energy_scheduler.sv
// Tick-paced arbiter applying saturating inc/dec steps to the shared energy level.
// Define ENERGY_SCHED_PRIO_EN to give requester 0 (sleep controller) absolute priority.
module energy_scheduler
  import mimosa_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int STEP       = DEF_STEP,
  parameter int TICK_DIV   = 16,
  parameter int LEVEL_INIT = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_inc,
  input  logic [N_REQ-1:0] req_dec,
  output logic [N_REQ-1:0] grant,
  output logic [WIDTH-1:0] level,
  output logic [1:0]       energy_indicator,
  output logic             sat_hit
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int DW = $clog2(TICK_DIV);
  localparam logic [WIDTH-1:0] LVL_MAX = '1;
  localparam logic [WIDTH-1:0] LVL_RST = WIDTH'(LEVEL_INIT);

  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] level_q, level_d;
  energy_ind_e      ind_q, ind_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             sat_q, sat_d;

  logic             slot;
  logic [N_REQ-1:0] pending, rr_pending, rr_winner, win_oh;
  logic             rr_valid, prio_win, win_vld;
  logic [PW-1:0]    win_idx;
  logic             sel_inc, sel_dec;
  logic [WIDTH:0]   sum, diff;

  assign pending = req_inc | req_dec;

`ifdef ENERGY_SCHED_PRIO_EN
  // Requester 0 bypasses the ring; the ring only sees 1..N_REQ-1.
  assign prio_win   = pending[0];
  assign rr_pending = pending & ~N_REQ'(1);
`else
  assign prio_win   = 1'b0;
  assign rr_pending = pending;
`endif

  rr_arbiter #(.N(N_REQ)) u_arb (
    .pending (rr_pending),
    .ptr     (rr_ptr_q),
    .winner  (rr_winner),
    .valid   (rr_valid)
  );

  always_comb begin
    slot      = (div_cnt_q == DW'(TICK_DIV - 1));
    div_cnt_d = slot ? '0 : div_cnt_q + 1'b1;

    win_oh  = prio_win ? N_REQ'(1) : rr_winner;
    win_vld = prio_win | rr_valid;
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win_oh[i]) win_idx = PW'(i);

    sel_inc = |(win_oh & req_inc);
    sel_dec = |(win_oh & req_dec);
    sum     = {1'b0, level_q} + (WIDTH+1)'(STEP);
    diff    = {1'b0, level_q} - (WIDTH+1)'(STEP);

    rr_ptr_d = rr_ptr_q;
    level_d  = level_q;
    grant_d  = '0;
    sat_d    = 1'b0;

    if (slot && win_vld) begin
      grant_d = win_oh;
      if (!prio_win)
        rr_ptr_d = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
      // Carry out / borrow at WIDTH+1 bits means the step was clipped.
      if (sel_inc && !sel_dec) begin
        level_d = sum[WIDTH] ? LVL_MAX : sum[WIDTH-1:0];
        sat_d   = sum[WIDTH];
      end else if (sel_dec && !sel_inc) begin
        level_d = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
        sat_d   = diff[WIDTH];
      end
    end

    ind_d = energy_ind_e'(level_d[WIDTH-1:WIDTH-2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      rr_ptr_q  <= '0;
      level_q   <= LVL_RST;
      ind_q     <= energy_ind_e'(LVL_RST[WIDTH-1:WIDTH-2]);
      grant_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      rr_ptr_q  <= rr_ptr_d;
      level_q   <= level_d;
      ind_q     <= ind_d;
      grant_q   <= grant_d;
      sat_q     <= sat_d;
    end
  end

  assign grant            = grant_q;
  assign level            = level_q;
  assign energy_indicator = ind_q;
  assign sat_hit          = sat_q;

endmodule

// File: tb/tb_energy_scheduler.sv
// Randomized and directed checks of energy_scheduler against a slot-level model.
module tb_energy_scheduler;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int STEP = 4;
  localparam int TD   = 16;
  localparam int LI   = 128;
  localparam int LMAX = (1 << W) - 1;
`ifdef ENERGY_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req_inc, req_dec, grant;
  logic [W-1:0] level;
  logic [1:0]   energy_indicator;
  logic         sat_hit;

  int n_chk  = 0;
  int n_fail = 0;
  int m_level, m_ptr;

  always #5 clk = ~clk;

  energy_scheduler #(
    .N_REQ(N), .WIDTH(W), .STEP(STEP), .TICK_DIV(TD), .LEVEL_INIT(LI)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_inc(req_inc), .req_dec(req_dec),
    .grant(grant), .level(level), .energy_indicator(energy_indicator),
    .sat_hit(sat_hit)
  );

  task automatic model_reset();
    m_level = LI;
    m_ptr   = 0;
  endtask

  // One slot period: post requests, confirm nothing moves until the TD-th edge,
  // then compare grant/level/indicator/sat_hit with the model.
  task automatic run_slot(input logic [N-1:0] inc, input logic [N-1:0] dec, input string tag);
    logic [N-1:0] pend, exp_grant;
    int win, nl;
    bit exp_sat, early;
    pend = inc | dec;
    win = -1;
    if (PRIO && pend[0]) win = 0;
    else
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (win < 0 && pend[idx] && !(PRIO && idx == 0)) win = idx;
      end
    exp_grant = '0;
    exp_sat   = 1'b0;
    nl        = m_level;
    if (win >= 0) begin
      exp_grant[win] = 1'b1;
      if (!(PRIO && win == 0)) m_ptr = (win + 1) % N;
      if (inc[win] && !dec[win]) begin
        nl = m_level + STEP;
        if (nl > LMAX) begin nl = LMAX; exp_sat = 1'b1; end
      end else if (dec[win] && !inc[win]) begin
        nl = m_level - STEP;
        if (nl < 0) begin nl = 0; exp_sat = 1'b1; end
      end
    end

    req_inc = inc;
    req_dec = dec;
    early = 1'b0;
    for (int c = 1; c <= TD; c++) begin
      @(posedge clk);
      #1;
      // Mid-period glitches must be ignored: only the slot-cycle sample counts.
      if (c == 3) begin req_inc = ~inc; req_dec = ~dec; end
      if (c == 6) begin req_inc = inc;  req_dec = dec;  end
      if (c < TD && (grant !== '0 || sat_hit !== 1'b0 || level !== W'(m_level))) early = 1'b1;
    end
    n_chk++;
    if (early) begin
      n_fail++;
      $display("FAIL %s quiet_between_slots: grant/level/sat moved before slot edge", tag);
    end
    n_chk++;
    if (grant !== exp_grant) begin
      n_fail++;
      $display("FAIL %s grant: got %b want %b", tag, grant, exp_grant);
    end
    m_level = nl;
    n_chk++;
    if (level !== W'(m_level)) begin
      n_fail++;
      $display("FAIL %s level: got %0d want %0d", tag, level, m_level);
    end
    n_chk++;
    if (energy_indicator !== 2'(m_level >> (W - 2))) begin
      n_fail++;
      $display("FAIL %s indicator: got %0d want %0d", tag, energy_indicator, m_level >> (W - 2));
    end
    n_chk++;
    if (sat_hit !== exp_sat) begin
      n_fail++;
      $display("FAIL %s sat_hit: got %b want %b", tag, sat_hit, exp_sat);
    end
    req_inc = '0;
    req_dec = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_inc = '0; req_dec = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (level !== W'(LI) || energy_indicator !== 2'd2 || grant !== '0 || sat_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: level=%0d ind=%0d grant=%b sat=%b want 128/2/0000/0",
               level, energy_indicator, grant, sat_hit);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alternate();
    for (int s = 0; s < 6; s++) run_slot(4'b0110, 4'b0000, "alternate");
  endtask

  task automatic test_sat_high();
    for (int s = 0; s < 40 && m_level < LMAX; s++) run_slot(4'b1000, 4'b0000, "sat_high_climb");
    run_slot(4'b1000, 4'b0000, "sat_high_at_max");
    run_slot(4'b1000, 4'b0000, "sat_high_at_max2");
  endtask

  task automatic test_sat_low();
    for (int s = 0; s < 70 && m_level > 0; s++) run_slot(4'b0000, 4'b0001, "sat_low_fall");
    run_slot(4'b0000, 4'b0001, "sat_low_at_zero");
    run_slot(4'b0010, 4'b0010, "cancel_at_zero");
  endtask

  task automatic test_all_four();
    for (int s = 0; s < 8; s++) run_slot(4'b1110, 4'b0001, "all_four");
  endtask

  task automatic test_idle();
    run_slot(4'b0000, 4'b0000, "idle");
    run_slot(4'b0000, 4'b0000, "idle2");
  endtask

  task automatic test_random();
    for (int s = 0; s < 40; s++)
      run_slot(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), "random");
  endtask

  task automatic test_reset_mid();
    req_inc = 4'b0110;
    req_dec = 4'b0001;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++;
    if (level !== W'(LI) || energy_indicator !== 2'd2 || grant !== '0 || sat_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: level=%0d ind=%0d grant=%b sat=%b want 128/2/0000/0",
               level, energy_indicator, grant, sat_hit);
    end
    repeat (8) @(posedge clk);
    #1;
    n_chk++;
    if (grant !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_no_grant: got %b want 0000", grant);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_slot(4'b0110, 4'b0001, "reset_mid_first");
    run_slot(4'b0110, 4'b0001, "reset_mid_second");
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_sat_high();
    test_sat_low();
    test_all_four();
    test_idle();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/energy_scheduler.md
# energy_scheduler

Shares the single creature energy level between all sources that want to raise or lower it: sleep controller, feeding, play and stress. Each source posts increment/decrement requests; a tick-paced round-robin arbiter grants one request per slot and applies it as a saturating step to the energy register. The quantised 2-bit `energy_indicator` it produces is the same signal `sleep_controller` consumes.

## Interface
- `N_REQ`, 4: number of requesters; index 0 is the sleep controller.
- `WIDTH`, 8: energy level width.
- `STEP`, 4: magnitude of one inc/dec; must be < 2^WIDTH.
- `TICK_DIV`, 16: clock cycles per arbitration slot; must be ≥ 2.
- `LEVEL_INIT`, 128: level after reset.

- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_inc` in N_REQ: per-requester increment request, level-held.
- `req_dec` in N_REQ: per-requester decrement request, level-held.
- `grant` out N_REQ: one-hot, single-cycle grant pulse.
- `level` out WIDTH: current energy level.
- `energy_indicator` out 2: `level[WIDTH-1:WIDTH-2]`, registered with `level`.
- `sat_hit` out 1: one-cycle pulse when an applied step was clipped.

## Operation
- Prescaler `div_cnt` counts 0..TICK_DIV-1 and wraps; a slot occurs on the cycle with `div_cnt == TICK_DIV-1`.
- Requester i is pending if `req_inc[i] | req_dec[i]`.
- On a slot cycle with ≥1 pending requester, the winner is the first pending index found searching upward from `rr_ptr`, modulo N_REQ. On the next edge:
  - `grant[winner]` = 1.
  - `level` is updated.
  - `rr_ptr` = (winner+1) mod N_REQ.
- Level arithmetic, evaluated at WIDTH+1 bits:
  - inc only: `min(level+STEP, 2^WIDTH-1)`.
  - dec only: `max(level-STEP, 0)`.
  - both inc and dec set: cancel. Grant is issued, level is unchanged, `sat_hit` = 0.
- `sat_hit` = 1 when the unclipped result differs from the stored result. This includes an inc at max or a dec at 0.
- No pending requester on a slot: no grant; `level` and `rr_ptr` unchanged.
- Requesters drop their request on the cycle `grant` is seen. A request still high at the next slot is a new request.
- Requests arriving or dropping between slots are ignored until the next slot. Only the slot-cycle sample matters.
- Reset, including mid-slot: `div_cnt`=0, `rr_ptr`=0, `level`=LEVEL_INIT, `energy_indicator`=LEVEL_INIT[WIDTH-1:WIDTH-2], `grant`=0, `sat_hit`=0. No grant is produced for a slot interrupted by reset.

## Timing
- Grant latency: 1 cycle after the slot cycle.
- `level`, `energy_indicator` and `sat_hit` change on the same edge as `grant`.
- Maximum one grant per TICK_DIV cycles.
- First slot after reset release: cycle TICK_DIV-1.
- Worst-case wait for a continuously pending requester: N_REQ slots.
- All outputs are registered; no combinational path from the `req_*` inputs to the outputs.

## Configuration
- `ENERGY_SCHED_PRIO_EN`:
  - Defined: requester 0 (sleep controller) wins any slot in which it is pending, regardless of `rr_ptr`. `rr_ptr` is not updated by a priority grant. Round-robin among requesters 1..N_REQ-1 is otherwise unchanged.
  - Undefined: pure round-robin over all N_REQ requesters.

## Structure
- Shared package `mimosa_pkg`:
  - indicator encoding constants `IND_LOW`=0, `IND_MED`=1, `IND_HIGH`=2, `IND_FULL`=3.
  - default `WIDTH` and `STEP`.
- Sub-module `rr_arbiter`:
  - parameter N.
  - inputs: `pending` vector and `ptr`.
  - outputs: one-hot `winner` and a valid flag.
  - purely combinational.
  - reused by other shared-counter schedulers (stress, hunger).

## Test plan
- Reset with LEVEL_INIT=128 → `level`=128, `energy_indicator`=2, `grant`=0; first grant no earlier than cycle 16 after `rst_n` rises.
- `req_inc` on requesters 1 and 2 held continuously, STEP=4 → grants alternate 1,2,1,2 every 16 cycles; `level` 132, 136, 140, ...
- Level 254, `req_inc[3]` → `level`=255, `sat_hit` pulses; a second inc at 255 → `level` stays 255, `sat_hit` pulses again.
- Level 2, `req_dec[0]` → `level`=0, `sat_hit`=1. Then `req_inc[1]` and `req_dec[1]` set together → grant[1], `level` stays 0, `sat_hit`=0.
- All four requesting, `ENERGY_SCHED_PRIO_EN` defined, `req_dec[0]` held → `grant[0]` every slot and `rr_ptr` unchanged. Without the macro → grants 0,1,2,3 in turn.
- `rst_n` pulsed low at `div_cnt`=10 with requests pending → no grant, `level` back to 128; next grant 1 cycle after the 16th cycle post-release.
